// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared types, default I/O memory map and error tag encoding
package bp_common_pkg;

  localparam int unsigned bp_dev_idx_width_lp = 8;

  // Tag carried through the in-order queue: device index or decode error.
  typedef struct packed {
    logic                           err;
    logic [bp_dev_idx_width_lp-1:0] idx;
  } bp_dev_id_s;

  localparam bp_dev_id_s bp_dev_err_c = '{err: 1'b1, idx: '0};

  localparam logic [31:0] bp_cfg_base_lp   = 32'h0100_0000;
  localparam logic [31:0] bp_clint_base_lp = 32'h0200_0000;
  localparam logic [31:0] bp_host_base_lp  = 32'h0300_0000;
  localparam logic [31:0] bp_dram_base_lp  = 32'h8000_0000;

  localparam logic [31:0] bp_cfg_mask_lp   = 32'hFF00_0000;
  localparam logic [31:0] bp_clint_mask_lp = 32'hFF00_0000;
  localparam logic [31:0] bp_host_mask_lp  = 32'hFF00_0000;
  localparam logic [31:0] bp_dram_mask_lp  = 32'h8000_0000;

endpackage

// File: rtl/bp_addr_region_match.sv
// rtl/bp_addr_region_match.sv - base/mask region compare with lowest-index priority
module bp_addr_region_match
  import bp_common_pkg::*;
#(
  parameter int                                  num_dev_p     = 4,
  parameter int                                  paddr_width_p = 56,
  parameter logic [num_dev_p*paddr_width_p-1:0]  dev_base_p    = '0,
  parameter logic [num_dev_p*paddr_width_p-1:0]  dev_mask_p    = '0
) (
  input  logic [paddr_width_p-1:0]       addr_i,
  output logic [num_dev_p-1:0]           match_oh_o,
  output logic [bp_dev_idx_width_lp-1:0] idx_o,
  output logic                           unmapped_o
);

  logic [num_dev_p-1:0]     hit;
  logic [paddr_width_p-1:0] base_i, mask_i;

  always_comb begin
    hit        = '0;
    match_oh_o = '0;
    idx_o      = '0;
    base_i     = '0;
    mask_i     = '0;
    for (int i = 0; i < num_dev_p; i++) begin
      base_i = dev_base_p[i*paddr_width_p +: paddr_width_p];
      mask_i = dev_mask_p[i*paddr_width_p +: paddr_width_p];
      hit[i] = ((addr_i & mask_i) == (base_i & mask_i));
    end
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = num_dev_p - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_oh_o    = '0;
        match_oh_o[i] = 1'b1;
        idx_o         = bp_dev_idx_width_lp'(i);
      end
    end
  end

  assign unmapped_o = ~|hit;

endmodule

// File: rtl/bp_fifo_1r1w.sv
// rtl/bp_fifo_1r1w.sv - small one-read one-write FIFO with occupancy count
module bp_fifo_1r1w #(
  parameter int els_p   = 4,
  parameter int width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  assign full_o = (count_q == cnt_w_lp'(els_p));
  assign v_o    = (count_q != '0);
  assign data_o = mem_q[rptr_q];
  assign enq    = v_i & ~full_o;
  assign deq    = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
    if (deq) rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_addr_map_router.sv
// rtl/bp_addr_map_router.sv - uncached I/O address-decode router, in-order responses (option: BP_ADDR_MAP_ROUTER_STATS_EN)
module bp_addr_map_router
  import bp_common_pkg::*;
#(
  parameter int paddr_width_p     = 56,
  parameter int data_width_p      = 64,
  parameter int num_dev_p         = 4,
  parameter logic [num_dev_p*paddr_width_p-1:0] dev_base_p = {
    paddr_width_p'(bp_dram_base_lp), paddr_width_p'(bp_host_base_lp),
    paddr_width_p'(bp_clint_base_lp), paddr_width_p'(bp_cfg_base_lp)},
  parameter logic [num_dev_p*paddr_width_p-1:0] dev_mask_p = {
    paddr_width_p'(bp_dram_mask_lp), paddr_width_p'(bp_host_mask_lp),
    paddr_width_p'(bp_clint_mask_lp), paddr_width_p'(bp_cfg_mask_lp)},
  parameter int max_outstanding_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cmd_v_i,
  input  logic [paddr_width_p-1:0]          cmd_addr_i,
  input  logic                              cmd_we_i,
  input  logic [data_width_p-1:0]           cmd_data_i,
  output logic                              cmd_ready_o,
  output logic [num_dev_p-1:0]              dev_cmd_v_o,
  output logic [paddr_width_p-1:0]          dev_cmd_addr_o,
  output logic                              dev_cmd_we_o,
  output logic [data_width_p-1:0]           dev_cmd_data_o,
  input  logic [num_dev_p-1:0]              dev_cmd_ready_i,
  input  logic [num_dev_p-1:0]              dev_resp_v_i,
  input  logic [num_dev_p*data_width_p-1:0] dev_resp_data_i,
  output logic [num_dev_p-1:0]              dev_resp_yumi_o,
  output logic                              resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic                              resp_err_o,
`ifdef BP_ADDR_MAP_ROUTER_STATS_EN
  output logic [31:0]                       err_count_o,
  output logic [num_dev_p*32-1:0]           issue_count_o,
`endif
  input  logic                              resp_yumi_i
);

  logic                      in_v_q, in_v_d;
  logic [paddr_width_p-1:0]  in_addr_q, in_addr_d;
  logic                      in_we_q, in_we_d;
  logic [data_width_p-1:0]   in_data_q, in_data_d;

  logic [num_dev_p-1:0]           match_oh;
  logic [bp_dev_idx_width_lp-1:0] match_idx;
  logic                           unmapped;
  logic                           q_full, head_v, issue_ok, in_fire, cmd_accept;
  bp_dev_id_s                     enq_tag, head_tag;

  bp_addr_region_match #(
    .num_dev_p    (num_dev_p),
    .paddr_width_p(paddr_width_p),
    .dev_base_p   (dev_base_p),
    .dev_mask_p   (dev_mask_p)
  ) u_match (
    .addr_i    (in_addr_q),
    .match_oh_o(match_oh),
    .idx_o     (match_idx),
    .unmapped_o(unmapped)
  );

  // No bypass on full: a same-cycle dequeue does not free a slot for issue.
  assign issue_ok    = in_v_q & ~q_full;
  assign in_fire     = issue_ok & (unmapped | |(dev_cmd_ready_i & match_oh));
  assign cmd_ready_o = ~in_v_q | in_fire;
  assign cmd_accept  = cmd_v_i & cmd_ready_o;
  assign enq_tag     = unmapped ? bp_dev_err_c : '{err: 1'b0, idx: match_idx};

  assign dev_cmd_v_o    = (issue_ok & ~unmapped) ? match_oh : '0;
  assign dev_cmd_addr_o = in_addr_q;
  assign dev_cmd_we_o   = in_we_q;
  assign dev_cmd_data_o = in_data_q;

  always_comb begin
    in_v_d    = in_v_q;
    in_addr_d = in_addr_q;
    in_we_d   = in_we_q;
    in_data_d = in_data_q;
    if (cmd_accept) begin
      in_v_d    = 1'b1;
      in_addr_d = cmd_addr_i;
      in_we_d   = cmd_we_i;
      in_data_d = cmd_data_i;
    end else if (in_fire) begin
      in_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_v_q    <= 1'b0;
      in_addr_q <= '0;
      in_we_q   <= 1'b0;
      in_data_q <= '0;
    end else begin
      in_v_q    <= in_v_d;
      in_addr_q <= in_addr_d;
      in_we_q   <= in_we_d;
      in_data_q <= in_data_d;
    end
  end

  bp_fifo_1r1w #(
    .els_p  (max_outstanding_p),
    .width_p($bits(bp_dev_id_s))
  ) u_tag_q (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (in_fire),
    .data_i (enq_tag),
    .full_o (q_full),
    .yumi_i (resp_yumi_i),
    .v_o    (head_v),
    .data_o (head_tag)
  );

  always_comb begin
    resp_v_o        = 1'b0;
    resp_data_o     = '0;
    resp_err_o      = 1'b0;
    dev_resp_yumi_o = '0;
    if (head_v) begin
      if (head_tag.err) begin
        resp_v_o   = 1'b1;
        resp_err_o = 1'b1;
      end else begin
        for (int i = 0; i < num_dev_p; i++) begin
          if (head_tag.idx == bp_dev_idx_width_lp'(i)) begin
            resp_v_o           = dev_resp_v_i[i];
            resp_data_o        = dev_resp_data_i[i*data_width_p +: data_width_p];
            dev_resp_yumi_o[i] = resp_yumi_i;
          end
        end
      end
    end
  end

`ifdef BP_ADDR_MAP_ROUTER_STATS_EN
  logic [31:0]                err_count_q, err_count_d;
  logic [num_dev_p-1:0][31:0] issue_count_q, issue_count_d;

  always_comb begin
    err_count_d   = err_count_q;
    issue_count_d = issue_count_q;
    if (in_fire & unmapped & (err_count_q != 32'hFFFF_FFFF))
      err_count_d = err_count_q + 32'd1;
    for (int i = 0; i < num_dev_p; i++) begin
      if (in_fire & ~unmapped & match_oh[i] & (issue_count_q[i] != 32'hFFFF_FFFF))
        issue_count_d[i] = issue_count_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_count_q   <= '0;
      issue_count_q <= '0;
    end else begin
      err_count_q   <= err_count_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign err_count_o   = err_count_q;
  assign issue_count_o = issue_count_q;
`endif

endmodule

// File: doc/bp_addr_map_router.md
Name: bp_addr_map_router

Overview:
- Parametrised successor to the fixed, constant-only memory map: a runtime address-decode router for the uncached I/O path.
- Accepts single-beat physical-address commands, matches each against `num_dev_p` base/mask regions, and forwards it to the selected device channel.
- Returns responses in command order. Unmapped addresses get an error response; they are never forwarded.
- Sits between the core's uncached port and the cfg/clint/host/plic/DRAM endpoints.

Parameters:
- `paddr_width_p`, 56, physical address width.
- `data_width_p`, 64, command/response data width.
- `num_dev_p`, 4, number of device channels (≥1).
- `dev_base_p`, {32'h8000_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000} zero-extended to `paddr_width_p`, flat per-device base vector; device 0 is in the LSBs.
- `dev_mask_p`, {32'h8000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000} zero-extended to `paddr_width_p`, flat per-device compare mask.
- `max_outstanding_p`, 4, depth of the in-order tag queue (≥2).

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous active-high reset.
- `cmd_v_i`  in  1  command valid.
- `cmd_addr_i`  in  `paddr_width_p`  command address.
- `cmd_we_i`  in  1  write (1) / read (0).
- `cmd_data_i`  in  `data_width_p`  write data.
- `cmd_ready_o`  out  1  command accepted when `cmd_v_i & cmd_ready_o`.
- `dev_cmd_v_o`  out  `num_dev_p`  one-hot per-device command valid.
- `dev_cmd_addr_o`  out  `paddr_width_p`  shared address.
- `dev_cmd_we_o`  out  1  shared write enable.
- `dev_cmd_data_o`  out  `data_width_p`  shared data.
- `dev_cmd_ready_i`  in  `num_dev_p`  per-device ready.
- `dev_resp_v_i`  in  `num_dev_p`  per-device response valid.
- `dev_resp_data_i`  in  `num_dev_p*data_width_p`  per-device response data.
- `dev_resp_yumi_o`  out  `num_dev_p`  per-device response consume.
- `resp_v_o`  out  1  response valid.
- `resp_data_o`  out  `data_width_p`  response data.
- `resp_err_o`  out  1  response is a decode error.
- `resp_yumi_i`  in  1  consumer takes response; only legal while `resp_v_o`=1.

Behaviour:
- Reset: all valids and yumis low.
  - `cmd_ready_o`=1.
  - `resp_err_o`=0, `resp_data_o`=0.
  - Input register empty, tag queue empty.
  - Reset mid-transaction drops all state; device-side cleanup is the system's responsibility.
- Decode:
  - Device i matches when `(addr & mask_i) == (base_i & mask_i)`.
  - Multiple matches: lowest index wins.
  - No match: tag is ERR.
  - Decode uses the registered address.
- Input stage: one-entry register loaded on command accept.
  - `cmd_ready_o` = `~in_v_r | in_fire`.
  - Accepting while the held command drains in the same cycle is legal (full throughput).
  - Latency: accept in cycle N → `dev_cmd_v_o` asserted in cycle N+1 at the earliest.
- Issue (`in_fire`) requires `in_v_r` and the tag queue not full. Full means the count equals `max_outstanding_p`; there is no bypass, even if a dequeue happens in the same cycle.
  - Mapped: `dev_cmd_v_o[sel]`=1 only while the queue is not full; fire occurs when `dev_cmd_ready_i[sel]`. On fire, enqueue the sel tag.
  - ERR: fires without driving any `dev_cmd_v_o`; enqueues the ERR tag.
  - Valid holds with stable payload until fire.
- Response:
  - When the queue is empty, `resp_v_o`=0.
  - Head is ERR: `resp_v_o`=1, `resp_err_o`=1, `resp_data_o`=0.
  - Head is dev d: `resp_v_o` = `dev_resp_v_i[d]`, `resp_data_o` = data slice d, `resp_err_o`=0. This is a combinational passthrough (0 cycles).
  - `resp_yumi_i` dequeues the head and asserts `dev_resp_yumi_o[d]` in the same cycle; no yumi goes to any device for an ERR head.
  - Responses from non-head devices are ignored (left pending).
- Counter: occupancy width `clog2(max_outstanding_p+1)`.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Read/write pointers wrap modulo `max_outstanding_p`.
- Writes also produce a response (ack); all commands are tagged identically.

Optional Feature:
- `BP_ADDR_MAP_ROUTER_STATS_EN` defined:
  - Adds output ports `err_count_o` (32) and `issue_count_o` (`num_dev_p*32`).
  - Both are saturating counters: increment on ERR enqueue and on per-device fire respectively.
  - Both reset to 0 and hold at 32'hFFFF_FFFF.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package (`bp_common_pkg`):
  - `bp_dev_id_s` typedef holding the device index plus ERR flag.
  - Default base/mask localparams (cfg, clint, host, DRAM).
  - ERR encoding constant.
- Sub-module `bp_addr_region_match`: combinational mask compare plus priority encode, outputting the one-hot match, index, and unmapped flag.
- Tag queue: instantiate the existing small 1r1w FIFO.

Test Plan:
- Read 0x0200_4000 with dev1 ready → `dev_cmd_v_o`=4'b0010 one cycle after accept; dev1 responds 64'hDEAD → `resp_data_o`=64'hDEAD, `resp_err_o`=0, `dev_resp_yumi_o`=4'b0010 on `resp_yumi_i`.
- Read 0x0500_0000 (unmapped) → no `dev_cmd_v_o`; `resp_v_o`=1, `resp_err_o`=1, `resp_data_o`=0.
- Commands to dev3 (0x8000_0000) then dev0 (0x0100_0010); dev0 responds first → `resp_v_o` stays 0 until dev3 responds; responses are delivered dev3 then dev0.
- Issue 5 commands with `resp_yumi_i`=0 → 4 issued; 5th held in the input register, `cmd_ready_o`=0; one yumi → 5th issues the following cycle.
- Back-to-back commands with devices always ready and `resp_yumi_i`=1 → one command accepted per cycle, with no bubble.
- Assert `reset_i` with 3 outstanding → next cycle `resp_v_o`=0, `cmd_ready_o`=1; with STATS_EN, `err_count_o`=0.
